line_mem_responder: RTL and testbench

- Backing-store responder on the cache-to-memory side of the data path.
- Accepts one 128-bit line read or write request at a time from the cache controller's memory-request port.
- Models a fixed access latency with a counter and returns a single-cycle `ready` pulse, plus read data where applicable.
- Sits under the MEM-stage cache FSM, on the opposite end of the `mem_req` / `mem_data` handshake from the cache.

---
 rtl/line_mem_responder.sv | 126 ++++++++++++
 tb/tb_line_mem_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// Fixed-latency 128-bit line backing store answering the cache's mem_req/mem_data handshake.
// Optional byte-strobe writes are enabled with `define LINE_MEM_WSTRB_EN.
module line_mem_responder #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_LINES = 1024
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         mem_req_valid,
  input  logic         mem_req_rw,
  input  logic [31:0]  mem_req_addr,
  input  logic [127:0] mem_req_data,
`ifdef LINE_MEM_WSTRB_EN
  input  logic [15:0]  mem_req_wstrb,
`endif
  input  logic [2:0]   excpt_in,
  output logic         mem_data_ready,
  output logic [127:0] mem_data_data,
  output logic         mem_err
);

  localparam int          AW        = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam logic [27:0] DEPTH_IDX = 28'(DEPTH_LINES);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("line_mem_responder: LATENCY must be within 1..15");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP, TURN} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic           hold_rw;
  logic [27:0]    hold_idx;
  logic [127:0]   hold_data;
  logic [15:0]    hold_strb;
  logic [15:0]    req_strb;
  logic [127:0]   mem [DEPTH_LINES];

  logic           accept;
  logic           go_resp;
  logic           nxt_rw;
  logic [27:0]    nxt_idx;
  logic           nxt_oor;
  logic           hold_oor;
  logic           unused_addr_bits;

`ifdef LINE_MEM_WSTRB_EN
  assign req_strb = mem_req_wstrb;
`else
  assign req_strb = '1;
`endif

  assign unused_addr_bits = ^mem_req_addr[3:0];

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    accept   = 1'b0;
    go_resp  = 1'b0;
    nxt_rw   = hold_rw;
    nxt_idx  = hold_idx;
    if (state == IDLE) begin
      accept  = mem_req_valid && (excpt_in == 3'd0);
      nxt_rw  = mem_req_rw;
      nxt_idx = mem_req_addr[31:4];
      go_resp = accept && (LATENCY == 1);
    end else if (state == BUSY) begin
      go_resp = (excpt_in == 3'd0) && (cnt == 4'd1);
    end
    nxt_oor  = (nxt_idx >= DEPTH_IDX);
    hold_oor = (hold_idx >= DEPTH_IDX);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      mem_data_ready <= 1'b0;
      mem_data_data  <= '0;
      mem_err        <= 1'b0;
    end else begin
      // Outputs are registered on entry to RESP; the TURN cycle guarantees a
      // preceding write has already landed before a following read samples the array.
      mem_data_ready <= go_resp;
      mem_err        <= go_resp && nxt_oor;
      mem_data_data  <= (go_resp && !nxt_rw && !nxt_oor) ? mem[nxt_idx[AW-1:0]] : '0;
      case (state)
        IDLE: if (accept) begin
          cnt   <= 4'(LATENCY - 1);
          state <= (LATENCY == 1) ? RESP : BUSY;
        end
        BUSY: if (excpt_in != 3'd0) begin
          cnt   <= 4'd0;
          state <= IDLE;
        end else begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= TURN;
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture: only read after an accept has loaded it.
  always_ff @(posedge clock) begin
    if (accept) begin
      hold_rw   <= mem_req_rw;
      hold_idx  <= mem_req_addr[31:4];
      hold_data <= mem_req_data;
      hold_strb <= req_strb;
    end
  end

  // NOTE: the line array is deliberately left out of reset; contents survive reset and map onto plain RAM.
  always_ff @(posedge clock) begin
    if (!reset && state == RESP && hold_rw && !hold_oor) begin
      for (int b = 0; b < 16; b++) begin
        if (hold_strb[b]) mem[hold_idx[AW-1:0]][8*b +: 8] <= hold_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: random line traffic against an array model,
// plus directed abort, reset, held-valid, range and (with LINE_MEM_WSTRB_EN) strobe cases.
module tb_line_mem_responder;

  localparam int LATENCY = 4;
  localparam int DEPTH   = 1024;
`ifdef LINE_MEM_WSTRB_EN
  localparam bit WSTRB = 1'b1;
`else
  localparam bit WSTRB = 1'b0;
`endif

  typedef struct {
    int           cyc;
    bit           rd;
    logic [127:0] data;
    bit           err;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         valid = 1'b0;
  logic         rw = 1'b0;
  logic [31:0]  addr = '0;
  logic [127:0] wdata = '0;
  logic [15:0]  strb = '0;
  logic [2:0]   excpt = '0;
  logic         mem_data_ready;
  logic [127:0] mem_data_data;
  logic         mem_err;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];
  logic [127:0] model [int];
  int   pool [16];

  line_mem_responder #(.LATENCY(LATENCY), .DEPTH_LINES(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_req_valid  (valid),
    .mem_req_rw     (rw),
    .mem_req_addr   (addr),
    .mem_req_data   (wdata),
`ifdef LINE_MEM_WSTRB_EN
    .mem_req_wstrb  (strb),
`endif
    .excpt_in       (excpt),
    .mem_data_ready (mem_data_ready),
    .mem_data_data  (mem_data_data),
    .mem_err        (mem_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: whole-line array with per-byte merge; out-of-range reads give zero.
  task automatic model_req(input bit r, input int idx, input logic [127:0] d,
                           input logic [15:0] s, output exp_t e);
    logic [127:0] line;
    e.cyc  = 0;
    e.rd   = !r;
    e.err  = (idx >= DEPTH);
    e.data = '0;
    if (idx < DEPTH) begin
      line = model.exists(idx) ? model[idx] : '0;
      if (r) begin
        for (int b = 0; b < 16; b++) if (s[b]) line[8*b +: 8] = d[8*b +: 8];
        model[idx] = line;
      end else begin
        e.data = line;
      end
    end
  endtask

  // Called just after a posedge with the DUT idle; returns just after the accepting edge.
  task automatic issue(input bit r, input logic [31:0] a, input logic [127:0] d,
                       input logic [15:0] s, input int block, input bit scramble, output int c);
    valid = 1'b1; rw = r; addr = a; wdata = d; strb = s;
    if (block > 0) begin
      excpt = 3'($urandom_range(1, 7));
      repeat (block) begin @(posedge clock); #1; end
      excpt = 3'd0;
    end
    @(posedge clock); #1;
    c = cyc;
    if (scramble) begin
      rw = 1'($urandom); addr = $urandom; strb = 16'($urandom);
      wdata = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Waits (bounded) for the ready pulse, then returns just after the edge into TURN.
  task automatic wait_ready(input bit drop, input bit resp_excpt);
    bit seen = 1'b0;
    for (int i = 0; i < LATENCY + 4; i++) begin
      @(negedge clock);
      if (mem_data_ready) begin seen = 1'b1; break; end
    end
    check("ready_seen", seen, 1'b1);
    if (resp_excpt) excpt = 3'($urandom_range(1, 7));
    @(posedge clock); #1;
    excpt = 3'd0;
    if (drop) valid = 1'b0;
  endtask

  task automatic txn(input bit r, input logic [31:0] a, input logic [127:0] d,
                     input logic [15:0] s, input int block, input bit resp_excpt);
    int   c;
    exp_t e;
    model_req(r, int'(a[31:4]), d, s, e);
    issue(r, a, d, s, block, 1'b1, c);
    e.cyc = c + LATENCY - 1;
    exp_q.push_back(e);
    wait_ready(1'b1, resp_excpt);
    @(posedge clock); #1;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (mem_data_ready) begin
        check("ready_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("ready_cycle", e.cyc, cyc);
          check("resp_err", mem_err, e.err);
          if (e.rd) check("resp_data", mem_data_data, e.data);
        end
      end else begin
        check("idle_outputs_zero", {mem_err, mem_data_data}, '0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   c;
    exp_t e;
    logic [127:0] d;
    logic [31:0]  a;
    int   idx;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    check("reset_ready", mem_data_ready, 1'b0);
    check("reset_data", mem_data_data, '0);
    check("reset_err", mem_err, 1'b0);
    @(posedge clock); #1;

    pool[0] = 4; pool[1] = 5; pool[2] = 7; pool[3] = 9; pool[4] = DEPTH - 1;
    for (int i = 5; i < 16; i++) pool[i] = int'($urandom_range(0, DEPTH - 1));
    for (int i = 0; i < 16; i++)
      txn(1'b1, {28'(pool[i]), 4'($urandom)}, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 0, 1'b0);

    // Basic write then read of the same line through a different byte offset.
    txn(1'b1, 32'h40, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF, 0, 1'b0);
    txn(1'b0, 32'h4C, '0, 16'h0, 0, 1'b0);

    // Held valid: TURN blocks re-acceptance, so the second accept lands one IDLE cycle later.
    model_req(1'b0, 7, '0, 16'h0, e);
    issue(1'b0, 32'h70, '0, 16'h0, 0, 1'b0, c);
    e.cyc = c + LATENCY - 1;
    exp_q.push_back(e);
    e.cyc = c + 2 * LATENCY + 1;
    exp_q.push_back(e);
    wait_ready(1'b0, 1'b0);
    wait_ready(1'b1, 1'b0);
    @(posedge clock); #1;

    // Exception abort in the second BUSY cycle: no pulse, line 5 unchanged.
    issue(1'b1, 32'h50, {4{32'hAAAAAAAA}}, 16'hFFFF, 0, 1'b0, c);
    @(posedge clock); #1;
    excpt = 3'b001;
    @(posedge clock); #1;
    excpt = 3'd0; valid = 1'b0;
    repeat (LATENCY + 2) @(posedge clock); #1;
    txn(1'b0, 32'h50, '0, 16'h0, 0, 1'b0);

    // Reset during BUSY: write of line 9 is dropped.
    issue(1'b1, 32'h90, {4{32'h55555555}}, 16'hFFFF, 0, 1'b0, c);
    @(posedge clock); #1;
    reset = 1'b1; valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check("reset_mid_ready", mem_data_ready, 1'b0);
    repeat (LATENCY + 2) @(posedge clock); #1;
    txn(1'b0, 32'h90, '0, 16'h0, 0, 1'b0);

    // Out of range: read, write, read again at the first illegal line.
    txn(1'b0, 32'(DEPTH) << 4, '0, 16'h0, 0, 1'b0);
    txn(1'b1, 32'(DEPTH) << 4, {4{32'hDEADBEEF}}, 16'hFFFF, 0, 1'b0);
    txn(1'b0, 32'(DEPTH) << 4, '0, 16'h0, 0, 1'b0);
    txn(1'b0, {28'(DEPTH - 1), 4'h0}, '0, 16'h0, 0, 1'b0);

`ifdef LINE_MEM_WSTRB_EN
    txn(1'b1, 32'hA0, '1, 16'hFFFF, 0, 1'b0);
    txn(1'b1, 32'hA0, '0, 16'h0003, 0, 1'b0);
    txn(1'b0, 32'hA0, '0, 16'h0, 0, 1'b0);
    txn(1'b1, 32'hA0, '0, 16'h0000, 0, 1'b0);
    txn(1'b0, 32'hA0, '0, 16'h0, 0, 1'b0);
`endif

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) idx = int'($urandom_range(DEPTH, DEPTH + 4096));
      else idx = pool[$urandom_range(0, 15)];
      a = {28'(idx), 4'($urandom)};
      d = {$urandom, $urandom, $urandom, $urandom};
      txn(1'($urandom), a, d, WSTRB ? 16'($urandom) : 16'hFFFF,
          ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0,
          $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end

    repeat (LATENCY + 4) @(posedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
